// File: rtl/poly_ram_arbiter.sv
// ---------------------------------------------------------------------------
// poly_ram_arbiter
//   Shares a single dual-port RAM between N_REQ requester engines. The write
//   port (A) and the read port (B) each have an independent round-robin
//   arbiter with burst locking. Every accepted read is tagged with the
//   requester that issued it, and the tag travels through a
//   COMMON_BRAM_DELAY-deep pipeline so that the delayed ram_doutb is
//   returned to the right requester.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   rd_req/rd_addr/rd_last   per-requester read requests (packed per requester)
//   rd_gnt         read grant, beat transfers on rd_req[i] & rd_gnt[i]
//   rd_rsp_valid   one-hot: rd_rsp_data belongs to requester i
//   rd_rsp_data    shared read data (ram_doutb)
//   wr_req/wr_addr/wr_data/wr_last, wr_gnt   write-side equivalents
//   ram_wea/ram_addra/ram_dina               RAM port A (write)
//   ram_addrb/ram_doutb                      RAM port B (read)
//
// Also contains poly_ram_rr_lock_arb, the per-port arbiter:
//   req/last in, one-hot gnt and its binary index out.
// ---------------------------------------------------------------------------

module poly_ram_rr_lock_arb #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [IDX_W:0] N_L   = (IDX_W+1)'(N_REQ);

  logic [0:0]       state_r;
  logic [IDX_W-1:0] owner_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_vld_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W:0]   cand_s;
  logic             hit_s;

  // Index after idx, wrapping at N_REQ (N_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    logic [IDX_W:0] nxt;
    nxt = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
    nxt = (nxt >= N_L) ? {(IDX_W+1){1'b0}} : nxt;
    return nxt[IDX_W-1:0];
  endfunction

  // Round-robin scan: first requester found starting at ptr_r, wrapping.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = {IDX_W{1'b0}};
    sum_s     = {(IDX_W+1){1'b0}};
    cand_s    = {(IDX_W+1){1'b0}};
    hit_s     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s     = {1'b0, ptr_r} + (IDX_W+1)'(k);
      cand_s    = (sum_s >= N_L) ? (sum_s - N_L) : sum_s;
      hit_s     = ~win_vld_s & req[cand_s[IDX_W-1:0]];
      win_idx_s = hit_s ? cand_s[IDX_W-1:0] : win_idx_s;
      win_vld_s = win_vld_s | hit_s;
    end
  end

  // Grant from registered state and live requests; reset masks everything
  // so no beat can be accepted on a reset edge.
  always_comb begin
    gnt     = {N_REQ{1'b0}};
    gnt_idx = {IDX_W{1'b0}};
    if (!rst_n) begin
      gnt     = {N_REQ{1'b0}};
      gnt_idx = {IDX_W{1'b0}};
    end else if (state_r == ST_LOCKED) begin
      // A stalled owner keeps the lock: nobody else is granted.
      gnt_idx      = owner_r;
      gnt[owner_r] = req[owner_r];
    end else begin
      gnt_idx        = win_idx_s;
      gnt[win_idx_s] = win_vld_s;
    end
  end

  // State, owner and pointer update on each transferred beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      owner_r <= {IDX_W{1'b0}};
      ptr_r   <= {IDX_W{1'b0}};
    end else if (|gnt) begin
      if (last[gnt_idx]) begin
        state_r <= ST_IDLE;
        ptr_r   <= wrap_inc(gnt_idx);
      end else begin
        // Burst continues: lock onto the winner, pointer stays put.
        state_r <= ST_LOCKED;
        owner_r <= gnt_idx;
      end
    end
  end

endmodule

module poly_ram_arbiter #(
  parameter int COE_WIDTH         = 39,
  parameter int ADDR_WIDTH        = 9,
  parameter int N_REQ             = 2,
  parameter int COMMON_BRAM_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              rd_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   rd_addr,
  input  logic [N_REQ-1:0]              rd_last,
  output logic [N_REQ-1:0]              rd_gnt,
  output logic [N_REQ-1:0]              rd_rsp_valid,
  output logic [COE_WIDTH-1:0]          rd_rsp_data,
  input  logic [N_REQ-1:0]              wr_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [N_REQ*COE_WIDTH-1:0]    wr_data,
  input  logic [N_REQ-1:0]              wr_last,
  output logic [N_REQ-1:0]              wr_gnt,
  output logic                          ram_wea,
  output logic [ADDR_WIDTH-1:0]         ram_addra,
  output logic [COE_WIDTH-1:0]          ram_dina,
  output logic [ADDR_WIDTH-1:0]         ram_addrb,
  input  logic [COE_WIDTH-1:0]          ram_doutb
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [N_REQ-1:0] tag_pipe_r [COMMON_BRAM_DELAY];

  poly_ram_rr_lock_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_req),
    .last    (rd_last),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx_s)
  );

  poly_ram_rr_lock_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req),
    .last    (wr_last),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx_s)
  );

  // Port A mux: idle port drives zeros so the RAM sees no stray writes.
  always_comb begin
    ram_wea   = 1'b0;
    ram_addra = {ADDR_WIDTH{1'b0}};
    ram_dina  = {COE_WIDTH{1'b0}};
    if (|wr_gnt) begin
      ram_wea   = 1'b1;
      ram_addra = wr_addr[wr_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      ram_dina  = wr_data[wr_idx_s*COE_WIDTH +: COE_WIDTH];
    end else begin
      ram_wea   = 1'b0;
      ram_addra = {ADDR_WIDTH{1'b0}};
      ram_dina  = {COE_WIDTH{1'b0}};
    end
  end

  // Port B address mux.
  always_comb begin
    ram_addrb = {ADDR_WIDTH{1'b0}};
    if (|rd_gnt) begin
      ram_addrb = rd_addr[rd_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin
      ram_addrb = {ADDR_WIDTH{1'b0}};
    end
  end

  // Tag pipeline matched to RAM latency; reset drops all in-flight tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < COMMON_BRAM_DELAY; k++) begin
        tag_pipe_r[k] <= {N_REQ{1'b0}};
      end
    end else begin
      tag_pipe_r[0] <= rd_gnt;
      for (int k = 1; k < COMMON_BRAM_DELAY; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
    end
  end

  assign rd_rsp_valid = tag_pipe_r[COMMON_BRAM_DELAY-1];
  assign rd_rsp_data  = ram_doutb;

endmodule

// File: tb/tb_poly_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_poly_ram_arbiter
//   Directed bench for poly_ram_arbiter with N_REQ=2 and a two-cycle RAM.
//   Stimulus drives one cycle at a time with hand-computed grants; accepted
//   reads push the expected response into a queue which a separate monitor
//   compares against rd_rsp_valid / rd_rsp_data when it falls due.
// ---------------------------------------------------------------------------

module tb_poly_ram_arbiter;

  localparam int CW  = 39;
  localparam int AW  = 9;
  localparam int NR  = 2;
  localparam int DLY = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     rd_req;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_last;
  logic [NR-1:0]     rd_gnt;
  logic [NR-1:0]     rd_rsp_valid;
  logic [CW-1:0]     rd_rsp_data;
  logic [NR-1:0]     wr_req;
  logic [NR*AW-1:0]  wr_addr;
  logic [NR*CW-1:0]  wr_data;
  logic [NR-1:0]     wr_last;
  logic [NR-1:0]     wr_gnt;
  logic              ram_wea;
  logic [AW-1:0]     ram_addra;
  logic [CW-1:0]     ram_dina;
  logic [AW-1:0]     ram_addrb;
  logic [CW-1:0]     ram_doutb;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct {
    int            due;
    logic [NR-1:0] vld;
    logic [CW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] model_mem [1<<AW];
  logic [CW-1:0] mem [1<<AW];
  logic [CW-1:0] rd_pipe [DLY];
  logic          mem_init_done = 1'b0;

  poly_ram_arbiter #(
    .COE_WIDTH         (CW),
    .ADDR_WIDTH        (AW),
    .N_REQ             (NR),
    .COMMON_BRAM_DELAY (DLY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_last      (rd_last),
    .rd_gnt       (rd_gnt),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .wr_gnt       (wr_gnt),
    .ram_wea      (ram_wea),
    .ram_addra    (ram_addra),
    .ram_dina     (ram_dina),
    .ram_addrb    (ram_addrb),
    .ram_doutb    (ram_doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] pat(input int a);
    logic [AW-1:0] a9;
    a9 = a[AW-1:0];
    return {6'h2A, 24'h5A5A5A, a9};
  endfunction

  // Read-first RAM with DLY cycles of read latency.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (ram_wea) begin
      mem[ram_addra] <= ram_dina;
    end
    rd_pipe[0] <= mem[ram_addrb];
    for (int k = 1; k < DLY; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign ram_doutb = rd_pipe[DLY-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_rsp();
    exp_t e;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("rsp_valid", 64'(rd_rsp_valid), 64'(e.vld));
      chk("rsp_data", 64'(rd_rsp_data), 64'(e.data));
    end else if (cyc > 0) begin
      chk("rsp_idle", 64'(rd_rsp_valid), 64'd0);
    end
  endtask

  always @(negedge clk) check_rsp();

  // One cycle: compare grants and RAM port drive, push expected read data.
  task automatic tick(input logic [NR-1:0] eg_rd, input logic [NR-1:0] eg_wr,
                      input bit push, input string tag);
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [CW-1:0] wd;
    exp_t          e;
    @(negedge clk);
    ra = '0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < NR; i++) begin
      if (eg_rd[i]) ra = rd_addr[i*AW +: AW];
      if (eg_wr[i]) begin
        wa = wr_addr[i*AW +: AW];
        wd = wr_data[i*CW +: CW];
      end
    end
    chk({tag, " rd_gnt"}, 64'(rd_gnt), 64'(eg_rd));
    chk({tag, " wr_gnt"}, 64'(wr_gnt), 64'(eg_wr));
    chk({tag, " ram_wea"}, 64'(ram_wea), 64'(|eg_wr));
    chk({tag, " ram_addra"}, 64'(ram_addra), 64'(wa));
    chk({tag, " ram_dina"}, 64'(ram_dina), 64'(wd));
    chk({tag, " ram_addrb"}, 64'(ram_addrb), 64'(ra));
    if (eg_rd != '0 && push) begin
      e.due  = cyc + DLY;
      e.vld  = eg_rd;
      e.data = model_mem[ra];
      exp_q.push_back(e);
    end
    if (eg_wr != '0) model_mem[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rd_req  = '0;
    rd_last = '0;
    rd_addr = '0;
    wr_req  = '0;
    wr_last = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) model_mem[i] = pat(i);
    set_idle();

    // Reset held 3 cycles with everyone requesting.
    rst_n   = 1'b0;
    rd_req  = 2'b11;
    rd_last = 2'b11;
    rd_addr = {9'd11, 9'd10};
    wr_req  = 2'b11;
    wr_last = 2'b11;
    wr_addr = {9'd21, 9'd20};
    wr_data = {39'h11_1111_1111, 39'h22_2222_2222};
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) tick(2'b00, 2'b00, 1'b1, "reset");
    rst_n = 1'b1;
    tick(2'b01, 2'b01, 1'b1, "post_reset0");
    tick(2'b10, 2'b10, 1'b1, "post_reset1");
    set_idle();
    tick(2'b00, 2'b00, 1'b1, "idle");

    // Write 0x1234 to addr 5 with a same-cycle read, then read it back.
    wr_req  = 2'b01;
    wr_last = 2'b01;
    wr_addr = {9'd0, 9'd5};
    wr_data = {39'd0, 39'h1234};
    rd_req  = 2'b10;
    rd_last = 2'b10;
    rd_addr = {9'd5, 9'd0};
    tick(2'b10, 2'b01, 1'b1, "same_cycle_rw");
    wr_req  = 2'b00;
    tick(2'b10, 2'b00, 1'b1, "read_after_write");
    set_idle();
    tick(2'b00, 2'b00, 1'b1, "idle");

    // Full contention on reads (and writes for three cycles).
    for (int i = 0; i < 4; i++) begin
      rd_req  = 2'b11;
      rd_last = 2'b11;
      rd_addr = {9'd200, 9'd100};
      wr_req  = (i < 3) ? 2'b11 : 2'b00;
      wr_last = 2'b11;
      wr_addr = {9'd71, 9'd70};
      wr_data = {39'h710 + 39'(i), 39'h700 + 39'(i)};
      tick((i % 2 == 0) ? 2'b01 : 2'b10,
           (i < 3) ? ((i % 2 == 0) ? 2'b10 : 2'b01) : 2'b00, 1'b1, "contention");
    end
    set_idle();
    tick(2'b00, 2'b00, 1'b1, "idle");

    // Four-beat burst by requester 0 locks out requester 1 on both ports.
    for (int i = 0; i < 4; i++) begin
      rd_req  = 2'b11;
      rd_addr = {9'd300, 9'(i)};
      rd_last = {1'b1, (i == 3)};
      wr_req  = 2'b11;
      wr_addr = {9'd410, 9'(400 + i)};
      wr_data = {39'h4100, 39'h4000 + 39'(i)};
      wr_last = {1'b1, (i == 3)};
      tick(2'b01, 2'b01, 1'b1, "burst_lock");
    end
    rd_req = 2'b10;
    wr_req = 2'b10;
    tick(2'b10, 2'b10, 1'b1, "after_burst");
    set_idle();

    // Owner stall: lock held while requester 0 drops its request.
    rd_req  = 2'b11;
    rd_addr = {9'd301, 9'd40};
    rd_last = 2'b10;
    tick(2'b01, 2'b00, 1'b1, "stall_start");
    rd_req = 2'b10;
    tick(2'b00, 2'b00, 1'b1, "stall_hold");
    tick(2'b00, 2'b00, 1'b1, "stall_hold");
    rd_req  = 2'b11;
    rd_addr = {9'd301, 9'd41};
    rd_last = 2'b11;
    tick(2'b01, 2'b00, 1'b1, "stall_resume");
    rd_req = 2'b10;
    tick(2'b10, 2'b00, 1'b1, "stall_other");
    set_idle();
    tick(2'b00, 2'b00, 1'b1, "idle");

    // Reset with a read in flight: its response must never appear.
    rd_req  = 2'b01;
    rd_last = 2'b01;
    rd_addr = {9'd0, 9'd50};
    tick(2'b01, 2'b00, 1'b0, "inflight");
    rst_n  = 1'b0;
    rd_req = 2'b00;
    tick(2'b00, 2'b00, 1'b1, "mid_reset");
    rst_n   = 1'b1;
    rd_req  = 2'b10;
    rd_last = 2'b10;
    rd_addr = {9'd60, 9'd0};
    tick(2'b10, 2'b00, 1'b1, "post_mid_reset");
    set_idle();

    for (int i = 0; i < DLY + 2; i++) tick(2'b00, 2'b00, 1'b1, "drain");
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/poly_ram_arbiter.md
# poly_ram_arbiter

Shares one `ram_model`/`dual_ram` instance between N_REQ requesters (e.g. Reduce, Trace and host load/unload engines). The write port (A) and the read port (B) are arbitrated independently. Each port uses round-robin arbitration with burst locking. The block tags every accepted read so that the delayed `ram_doutb` is returned to the requester that issued it. It sits between the requester engines and the RAM model and is the only driver of the RAM ports.

## Interface
Parameters:
- COE_WIDTH, 39, data width; must match the RAM.
- ADDR_WIDTH, 9, address width; must match the RAM.
- N_REQ, 2, number of requesters (2..8).
- COMMON_BRAM_DELAY, 1, RAM read latency in cycles (≥1); must match the RAM.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_req  in  N_REQ  read request per requester.
- rd_addr  in  N_REQ*ADDR_WIDTH  read address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_last  in  N_REQ  marks the final beat of a read burst.
- rd_gnt  out  N_REQ  read grant; a beat transfers when rd_req[i] & rd_gnt[i].
- rd_rsp_valid  out  N_REQ  one-hot strobe: read data is for requester i.
- rd_rsp_data  out  COE_WIDTH  read data, shared by all requesters; equals ram_doutb.
- wr_req, wr_addr, wr_data, wr_last, wr_gnt: write-side equivalents (wr_data is N_REQ*COE_WIDTH).
- ram_wea  out  1  to RAM port A.
- ram_addra  out  ADDR_WIDTH  to RAM port A.
- ram_dina  out  COE_WIDTH  to RAM port A.
- ram_addrb  out  ADDR_WIDTH  to RAM port B.
- ram_doutb  in  COE_WIDTH  from RAM port B.

## Operation
- Read and write ports each have their own arbiter: a 2-state FSM (IDLE, LOCKED), an owner register and a round-robin pointer `ptr`.
- IDLE:
  - Winner = the first requester with req set, scanning ptr, ptr+1, … mod N_REQ.
  - gnt is one-hot to the winner, or zero if no request.
  - Grant is combinational from the registered state and the current req.
- Transfer with last=1: the state stays IDLE and ptr becomes winner+1 mod N_REQ.
- Transfer with last=0: the state goes to LOCKED, owner = winner, and ptr is unchanged.
- LOCKED:
  - gnt = owner bit & req[owner].
  - No other requester is granted, even if the owner deasserts req (an owner stall holds the lock).
  - An owner transfer with last=1 returns the state to IDLE and sets ptr = owner+1 mod N_REQ.
- Write beat: ram_wea=1 and ram_addra/ram_dina are muxed from the granted requester in the same cycle. When there is no write grant, ram_wea=0 and addr/data are 0.
- Read beat: ram_addrb is muxed from the granted requester (0 when there is no grant). A one-hot tag (or zero) enters a COMMON_BRAM_DELAY-deep shift register; its output drives rd_rsp_valid.
- Responses come back strictly in issue order, one per accepted read, with no drops. Requesters have no backpressure on responses.
- Same-cycle write and read to the same address: the read returns the old data (read-first). The next-cycle read returns the new data.
- rd_req/wr_req must stay asserted with stable addr/data until granted. Grants never assert to a non-requesting requester.

## Timing
- Reset (rst_n=0 at a clk edge) forces:
  - rd_gnt, wr_gnt, rd_rsp_valid, ram_wea = 0.
  - Both FSMs to IDLE and both ptr to 0.
  - The tag pipeline cleared.
- Reset in the middle of a burst or with reads in flight: locks are dropped and pending responses are discarded. No rd_rsp_valid is asserted for any beat accepted before reset.
- Reset assertion takes priority over every same-cycle event.
- Read latency: a read handshake at edge T gives rd_rsp_valid and valid data at edge T+COMMON_BRAM_DELAY.
- Write latency: the RAM is updated at the handshake edge.
- Throughput: each port sustains 1 beat/cycle, and reads and writes proceed concurrently.
- Single-beat bursts from all N_REQ requesters under full contention are served strictly in turn. Worst-case wait is N_REQ-1 bursts.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all req=1 → every gnt, rd_rsp_valid and ram_wea stays 0. First grant after release goes to requester 0.
- Write then read, N_REQ=2, DELAY=2:
  - Req0 writes 0x1234 to addr 5 (last=1).
  - Next cycle, req1 reads addr 5 → rd_rsp_valid=2'b10 with data 0x1234 exactly 2 cycles after the read handshake.
  - A same-cycle read of addr 5 returns the previous contents.
- Contention: both requesters issue single-beat reads every cycle → rd_gnt sequence 01,10,01,10. Responses alternate correspondingly.
- Burst lock: req0 reads addrs 0..3 (last on the 4th beat) while req1 requests from cycle 0 → req1 is first granted in cycle 4. The four req0 responses precede req1's.
- Owner stall: req0 drops rd_req for 2 cycles mid-burst → rd_gnt=0 for those cycles despite req1 requesting. The burst resumes with req0.
- Reset mid-flight: a read is accepted with DELAY=2 and rst_n=0 on the next edge → no rd_rsp_valid pulse follows. After release, a new read from req1 is granted immediately.
